// File: rtl/column_cursor_pkg.sv
// Shared defaults and helpers for the column_cursor block.
// Auto-repeat is compiled in only when COLUMN_CURSOR_AUTOREPEAT_EN is defined.
package column_cursor_pkg;

    localparam int NCOLS_DEF        = 3;
    localparam int HW_DEF           = 3;
    localparam int DEB_CYCLES_DEF   = 4;
    localparam int REPEAT_DELAY_DEF = 8;
    localparam int REPEAT_RATE_DEF  = 4;

    // Column the brick starts in after reset (and after recovering from an illegal col).
    function automatic int reset_col(input int ncols);
        return ncols / 2;
    endfunction

endpackage

// File: rtl/column_cursor_button_conditioner.sv
// One raw push-button -> 2-flop synchronizer -> debouncer -> one-cycle move pulse.
// With COLUMN_CURSOR_AUTOREPEAT_EN defined, a held button also emits repeat pulses.
module button_conditioner
    import column_cursor_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF
`ifdef COLUMN_CURSOR_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int REPEAT_RATE  = REPEAT_RATE_DEF
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic          deb_d;
    logic          deb_prev_q;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;
    logic          press;
    logic          pulse_q;
    logic          pulse_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            cnt_q      <= '0;
            pulse_q    <= 1'b0;
        end else begin
            sync1_q    <= btn_i;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
            pulse_q    <= pulse_d;
        end
    end

    // Level flips on the DEB_CYCLES-th consecutive disagreeing sample; any agreement restarts the count.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == DEB_LAST) begin
                deb_d = ~deb_q;
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end
    end

    assign press = deb_q & ~deb_prev_q;

`ifdef COLUMN_CURSOR_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = $clog2(REP_MAX + 1);
    localparam logic [RW-1:0] DELAY_W = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RATE_W  = RW'(REPEAT_RATE);

    logic          rep_arm_q;
    logic          rep_arm_d;
    logic          rep_first_q;
    logic          rep_first_d;
    logic [RW-1:0] rep_cnt_q;
    logic [RW-1:0] rep_cnt_d;
    logic          rep_gate;
    logic          rep_fire;

    // Repeats need the level high now and staying high, so a release stops them on the flip edge.
    assign rep_gate = deb_q & deb_d;
    assign rep_fire = rep_arm_q & rep_gate
                      & (rep_cnt_q == (rep_first_q ? DELAY_W : RATE_W));

    always_comb begin
        rep_arm_d   = rep_arm_q;
        rep_first_d = rep_first_q;
        rep_cnt_d   = rep_cnt_q;
        if (press) begin
            rep_arm_d   = 1'b1;
            rep_first_d = 1'b1;
            rep_cnt_d   = RW'(1);
        end else if (!rep_gate) begin
            rep_arm_d   = 1'b0;
            rep_first_d = 1'b0;
            rep_cnt_d   = '0;
        end else if (rep_fire) begin
            rep_first_d = 1'b0;
            rep_cnt_d   = RW'(1);
        end else if (rep_arm_q) begin
            rep_cnt_d   = rep_cnt_q + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_arm_q   <= 1'b0;
            rep_first_q <= 1'b0;
            rep_cnt_q   <= '0;
        end else begin
            rep_arm_q   <= rep_arm_d;
            rep_first_q <= rep_first_d;
            rep_cnt_q   <= rep_cnt_d;
        end
    end

    assign pulse_d = press | rep_fire;
`else
    assign pulse_d = press;
`endif

    assign pulse_o = pulse_q;

endmodule

// File: rtl/column_cursor.sv
// Falling-brick column cursor: debounced left/right moves gated by column stack heights.
// Define COLUMN_CURSOR_AUTOREPEAT_EN to enable auto-repeat while a button is held.
module column_cursor
    import column_cursor_pkg::*;
#(
    parameter int NCOLS        = NCOLS_DEF,
    parameter int HW           = HW_DEF,
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int REPEAT_RATE  = REPEAT_RATE_DEF,
    localparam int CW          = $clog2(NCOLS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_right,
    input  logic                btn_left,
    input  logic                enable,
    input  logic [NCOLS*HW-1:0] heights,
    input  logic [HW-1:0]       row,
    output logic [CW-1:0]       col,
    output logic                moved,
    output logic                blocked
);

    localparam logic [CW-1:0] RESET_COL = CW'(reset_col(NCOLS));
    localparam logic [CW-1:0] LAST_COL  = CW'(NCOLS - 1);

    if (NCOLS < 2 || DEB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("column_cursor: illegal parameter value");
    end

    logic          pulse_right;
    logic          pulse_left;
    logic          req_right;
    logic          req_left;
    logic          col_valid;
    logic          tgt_in_range;
    logic          tgt_free;
    logic [CW-1:0] tgt;
    logic [HW-1:0] tgt_height;
    logic [CW-1:0] col_q;
    logic [CW-1:0] col_d;
    logic          moved_q;
    logic          moved_d;
    logic          blocked_q;
    logic          blocked_d;

    button_conditioner #(
        .DEB_CYCLES   (DEB_CYCLES)
`ifdef COLUMN_CURSOR_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
`endif
    ) u_right (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_right),
        .pulse_o (pulse_right)
    );

    button_conditioner #(
        .DEB_CYCLES   (DEB_CYCLES)
`ifdef COLUMN_CURSOR_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
`endif
    ) u_left (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_left),
        .pulse_o (pulse_left)
    );

    // Simultaneous pulses cancel: neither a move nor a refusal.
    assign req_right = pulse_right & ~pulse_left;
    assign req_left  = pulse_left & ~pulse_right;
    assign col_valid = (col_q <= LAST_COL);

    always_comb begin
        tgt          = col_q;
        tgt_in_range = 1'b0;
        if (req_right) begin
            tgt_in_range = (col_q < LAST_COL);
            tgt          = col_q + CW'(1);
        end else if (req_left) begin
            tgt_in_range = (col_q != '0);
            tgt          = col_q - CW'(1);
        end
    end

    always_comb begin
        tgt_height = '0;
        for (int i = 0; i < NCOLS; i++) begin
            if (tgt == CW'(i)) begin
                tgt_height = heights[i*HW +: HW];
            end
        end
    end

    assign tgt_free = (row > tgt_height);

    always_comb begin
        col_d     = col_q;
        moved_d   = 1'b0;
        blocked_d = 1'b0;
        if (!col_valid) begin
            col_d = RESET_COL;
        end else if ((req_right | req_left) && enable) begin
            if (tgt_in_range && tgt_free) begin
                col_d   = tgt;
                moved_d = 1'b1;
            end else begin
                blocked_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q     <= RESET_COL;
            moved_q   <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            col_q     <= col_d;
            moved_q   <= moved_d;
            blocked_q <= blocked_d;
        end
    end

    assign col     = col_q;
    assign moved   = moved_q;
    assign blocked = blocked_q;

endmodule
